any1_rob: RTL and testbench
===========================

# any1_rob

Parametrised in-order reorder buffer for the ANY-1 core, sitting between decode/dispatch and register-file writeback. It allocates one entry per instruction in program order and accepts out-of-order results on several writeback ports. It commits up to CMT_WIDTH completed entries per cycle in order, and raises precise exceptions and branch redirects at commit. It generalises the fixed 32-entry, single-commit ROB entry scheme to configurable depth, writeback port count and commit width.

## Interface
- DEPTH, 32, entry count; power of 2, 4..64; RIDW = $clog2(DEPTH)
- WB_PORTS, 2, number of result writeback ports, 1..4
- CMT_WIDTH, 2, max commits per cycle, 1..4, ≤ DEPTH
- AWID, 32, address width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  external flush; discards all entries
- alloc_i  in  1  allocate request
- alloc_ip_i  in  AWID  instruction address
- alloc_rfwr_i  in  1  entry writes register file
- alloc_Rt_i  in  8  target register
- alloc_ready_o  out  1  entry available; comb from registered count
- alloc_rid_o  out  RIDW  rid granted (current tail index)
- wb_v_i  in  WB_PORTS  result valid per port
- wb_rid_i  in  WB_PORTS*RIDW  target rid per port
- wb_res_i  in  WB_PORTS*64  result per port
- wb_cause_i  in  WB_PORTS*16  fault cause per port; 0 = none
- wb_redir_i  in  WB_PORTS  mispredict; redirect at commit
- wb_tgt_i  in  WB_PORTS*AWID  redirect target per port
- cmt_v_o  out  CMT_WIDTH  slot committed this cycle, registered
- cmt_rfwr_o  out  CMT_WIDTH  slot writes register file
- cmt_Rt_o  out  CMT_WIDTH*8  slot target register
- cmt_res_o  out  CMT_WIDTH*64  slot result
- exc_o  out  1  exception pulse, registered
- exc_cause_o  out  16  cause of faulting entry
- exc_ip_o  out  AWID  ip of faulting entry
- redir_o  out  1  redirect pulse, registered
- redir_tgt_o  out  AWID  redirect target
- count_o  out  RIDW+1  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Pointers head/tail have RIDW+1 bits. The extra wrap bit distinguishes full from empty. count = tail − head mod 2^(RIDW+1).
- Allocation: fires on alloc_i && alloc_ready_o. Writes v=1, done=0, ip, rfwr, Rt, cause=0 at tail; tail++. alloc_ready_o = count < DEPTH. A commit in the same cycle does not free a slot for that cycle's allocation.
- Writeback: each valid port whose entry has v=1 sets done and stores res, cause, redir, tgt. A writeback to an entry with v=0 is ignored. If two ports target the same rid, the lower port index wins.
- Commit scan: from head, take slots k = 0..CMT_WIDTH−1 while the entry is v && done. The scan stops at the first non-done entry.
- An entry with cause≠0 commits only in slot 0. If found at k>0, the group ends before it.
  - At slot 0 it asserts exc_o with its cause and ip. No regfile write: cmt_v_o[0]=1 and cmt_rfwr_o[0]=0.
  - All entries are then flushed (head=tail, all v cleared).
- An entry with redir=1 ends the group (it is the last slot). redir_o and redir_tgt_o are asserted, and all younger entries are flushed.
- Committed entries: v cleared, head += number committed.
- Flush: clears all v/done and sets head=tail=0. Allocation and writeback in the flush cycle are dropped, and alloc_ready_o is forced low. Any commit computed in that cycle is suppressed: cmt_v_o=0 next cycle.
- Internal flush (exception or redirect) takes effect at the same edge as the commit outputs. Same-cycle allocations are dropped.

## Timing
- Reset (async, rst_ni low): head=tail=0; all v/done=0.
  - cmt_v_o, cmt_rfwr_o, cmt_Rt_o, cmt_res_o, exc_o, exc_cause_o, exc_ip_o, redir_o, redir_tgt_o all 0.
  - count_o=0, empty_o=1, alloc_ready_o=1, alloc_rid_o=0.
- Reset mid-operation discards all state immediately.
- Allocate sampled at edge E: the entry is visible at E+1.
- Writeback sampled at edge E sets done after E. The commit decision is made in cycle E..E+1, and cmt_v_o asserts after edge E+1. Minimum writeback-to-commit latency is 2 edges.
- cmt_*, exc_o and redir_o are single-cycle pulses.
- Wrap-around: indices are taken mod DEPTH. A commit group may span index DEPTH−1 → 0.

## Test plan
- Reset then DEPTH=32 allocations with no writeback → alloc_rid_o 0..31, alloc_ready_o low after the 32nd, count_o=32; a 33rd alloc_i is ignored.
- Allocate rids 0..3, write back in order 3,2,1,0 on port 0 → no commit until rid 0 is done; then cmt_v_o=2'b11 (rids 0,1), then 2'b11 (rids 2,3), empty_o=1.
- Rids 0..2 done; rid 1 has cause=16'h0037 → cycle 1: commit rid 0 only. Cycle 2: exc_o=1, exc_cause_o=0037, exc_ip_o = rid 1 ip, cmt_rfwr_o[0]=0; count_o=0 afterwards.
- Rid 0 done with redir=1, tgt=32'hFFFD0100; rids 1..3 done → redir_o=1 with that target, only rid 0 committed, rids 1..3 discarded.
- Ports 0 and 1 write back to the same rid 5 in one cycle, res A/B → the committed result equals port 0's value A.
- Fill to 30, commit 4, allocate 6 across the wrap → alloc_rid_o wraps 30,31,0,1,2,3; a commit group spanning 31→0 commits in order. Assert flush_i mid-stream → count_o=0 and no cmt_v_o the next cycle.

Source files
------------

// File: rtl/any1_rob.sv
// In-order reorder buffer: allocates entries in program order, accepts
// out-of-order results on WB_PORTS writeback ports and retires up to
// CMT_WIDTH completed entries per cycle, raising exceptions and branch
// redirects at commit.
module any1_rob #(
    parameter int DEPTH     = 32,
    parameter int WB_PORTS  = 2,
    parameter int CMT_WIDTH = 2,
    parameter int AWID      = 32,
    localparam int RIDW     = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      alloc_i,
    input  logic [AWID-1:0]           alloc_ip_i,
    input  logic                      alloc_rfwr_i,
    input  logic [7:0]                alloc_Rt_i,
    output logic                      alloc_ready_o,
    output logic [RIDW-1:0]           alloc_rid_o,
    input  logic [WB_PORTS-1:0]       wb_v_i,
    input  logic [WB_PORTS*RIDW-1:0]  wb_rid_i,
    input  logic [WB_PORTS*64-1:0]    wb_res_i,
    input  logic [WB_PORTS*16-1:0]    wb_cause_i,
    input  logic [WB_PORTS-1:0]       wb_redir_i,
    input  logic [WB_PORTS*AWID-1:0]  wb_tgt_i,
    output logic [CMT_WIDTH-1:0]      cmt_v_o,
    output logic [CMT_WIDTH-1:0]      cmt_rfwr_o,
    output logic [CMT_WIDTH*8-1:0]    cmt_Rt_o,
    output logic [CMT_WIDTH*64-1:0]   cmt_res_o,
    output logic                      exc_o,
    output logic [15:0]               exc_cause_o,
    output logic [AWID-1:0]           exc_ip_o,
    output logic                      redir_o,
    output logic [AWID-1:0]           redir_tgt_o,
    output logic [RIDW:0]             count_o,
    output logic                      empty_o
);

    typedef logic [RIDW-1:0] rid_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [RIDW:0]    head_q, head_d, tail_q, tail_d, count_w;
    logic [DEPTH-1:0] e_v_q, e_v_d, e_done_q, e_done_d;
    logic [DEPTH-1:0] e_rfwr_q, e_rfwr_d, e_redir_q, e_redir_d;
    logic [AWID-1:0]  e_ip_q    [DEPTH];
    logic [AWID-1:0]  e_ip_d    [DEPTH];
    logic [AWID-1:0]  e_tgt_q   [DEPTH];
    logic [AWID-1:0]  e_tgt_d   [DEPTH];
    logic [7:0]       e_rt_q    [DEPTH];
    logic [7:0]       e_rt_d    [DEPTH];
    logic [15:0]      e_cause_q [DEPTH];
    logic [15:0]      e_cause_d [DEPTH];
    logic [63:0]      e_res_q   [DEPTH];
    logic [63:0]      e_res_d   [DEPTH];

    rid_t                 scan_idx [CMT_WIDTH];
    logic [CMT_WIDTH-1:0] slot_v, slot_rfwr;
    logic [RIDW:0]        ncmt;
    logic                 exc_hit, redir_hit, alloc_fire;
    rid_t                 redir_idx, head_idx, tail_idx;

    logic [CMT_WIDTH-1:0]    cmt_v_q, cmt_v_d, cmt_rfwr_q, cmt_rfwr_d;
    logic [CMT_WIDTH*8-1:0]  cmt_rt_q, cmt_rt_d;
    logic [CMT_WIDTH*64-1:0] cmt_res_q, cmt_res_d;
    logic                    exc_q, exc_d, redir_pulse_q, redir_pulse_d;
    logic [15:0]             exc_cause_q, exc_cause_d;
    logic [AWID-1:0]         exc_ip_q, exc_ip_d, redir_tgt_q, redir_tgt_d;

    assign head_idx      = head_q[RIDW-1:0];
    assign tail_idx      = tail_q[RIDW-1:0];
    assign count_w       = tail_q - head_q;
    assign alloc_ready_o = (count_w < (RIDW+1)'(DEPTH)) && !flush_i;
    assign alloc_fire    = alloc_i && alloc_ready_o;

    // Commit scan: walk from head, stop at the first entry that cannot retire.
    always_comb begin
        logic stop;
        stop      = 1'b0;
        slot_v    = '0;
        slot_rfwr = '0;
        ncmt      = '0;
        exc_hit   = 1'b0;
        redir_hit = 1'b0;
        redir_idx = '0;
        for (int k = 0; k < CMT_WIDTH; k++) begin
            scan_idx[k] = head_idx + rid_t'(k);
            if (!stop) begin
                if (e_v_q[scan_idx[k]] && e_done_q[scan_idx[k]]) begin
                    if (e_cause_q[scan_idx[k]] != 16'h0) begin
                        // A faulting entry only retires alone, from slot 0.
                        if (k == 0) begin
                            slot_v[0] = 1'b1;
                            exc_hit   = 1'b1;
                        end
                        stop = 1'b1;
                    end else begin
                        slot_v[k]    = 1'b1;
                        slot_rfwr[k] = e_rfwr_q[scan_idx[k]];
                        ncmt         = ncmt + {{RIDW{1'b0}}, 1'b1};
                        if (e_redir_q[scan_idx[k]]) begin
                            redir_hit = 1'b1;
                            redir_idx = scan_idx[k];
                            stop      = 1'b1;
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Next entry state: allocate, write back, retire, then apply flushes.
    always_comb begin
        rid_t r;
        head_d    = head_q;
        tail_d    = tail_q;
        e_v_d     = e_v_q;
        e_done_d  = e_done_q;
        e_rfwr_d  = e_rfwr_q;
        e_redir_d = e_redir_q;
        e_ip_d    = e_ip_q;
        e_tgt_d   = e_tgt_q;
        e_rt_d    = e_rt_q;
        e_cause_d = e_cause_q;
        e_res_d   = e_res_q;
        r         = '0;
        if (alloc_fire) begin
            e_v_d[tail_idx]     = 1'b1;
            e_done_d[tail_idx]  = 1'b0;
            e_rfwr_d[tail_idx]  = alloc_rfwr_i;
            e_redir_d[tail_idx] = 1'b0;
            e_ip_d[tail_idx]    = alloc_ip_i;
            e_rt_d[tail_idx]    = alloc_Rt_i;
            e_cause_d[tail_idx] = 16'h0;
            tail_d              = tail_q + {{RIDW{1'b0}}, 1'b1};
        end
        // Highest port first so a lower port targeting the same rid wins.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            r = wb_rid_i[p*RIDW +: RIDW];
            if (wb_v_i[p] && e_v_q[r]) begin
                e_done_d[r]  = 1'b1;
                e_res_d[r]   = wb_res_i[p*64 +: 64];
                e_cause_d[r] = wb_cause_i[p*16 +: 16];
                e_redir_d[r] = wb_redir_i[p];
                e_tgt_d[r]   = wb_tgt_i[p*AWID +: AWID];
            end
        end
        for (int k = 0; k < CMT_WIDTH; k++) begin
            if (slot_v[k]) e_v_d[scan_idx[k]] = 1'b0;
        end
        head_d = head_q + ncmt;
        if (exc_hit || redir_hit) begin
            // Everything still in flight is younger than the retiring entry.
            e_v_d    = '0;
            e_done_d = '0;
            head_d   = tail_q;
            tail_d   = tail_q;
        end
        if (flush_i) begin
            e_v_d    = '0;
            e_done_d = '0;
            head_d   = '0;
            tail_d   = '0;
        end
    end

    // Registered commit / exception / redirect outputs, killed by flush.
    always_comb begin
        cmt_v_d       = flush_i ? '0 : slot_v;
        cmt_rfwr_d    = flush_i ? '0 : slot_rfwr;
        cmt_rt_d      = '0;
        cmt_res_d     = '0;
        for (int k = 0; k < CMT_WIDTH; k++) begin
            if (slot_v[k] && !flush_i) begin
                cmt_rt_d[k*8 +: 8]   = e_rt_q[scan_idx[k]];
                cmt_res_d[k*64 +: 64] = e_res_q[scan_idx[k]];
            end
        end
        exc_d         = exc_hit && !flush_i;
        exc_cause_d   = exc_d ? e_cause_q[head_idx] : 16'h0;
        exc_ip_d      = exc_d ? e_ip_q[head_idx] : '0;
        redir_pulse_d = redir_hit && !flush_i;
        redir_tgt_d   = redir_pulse_d ? e_tgt_q[redir_idx] : '0;
    end

    // Control state and outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q        <= '0;
            tail_q        <= '0;
            e_v_q         <= '0;
            e_done_q      <= '0;
            cmt_v_q       <= '0;
            cmt_rfwr_q    <= '0;
            cmt_rt_q      <= '0;
            cmt_res_q     <= '0;
            exc_q         <= 1'b0;
            exc_cause_q   <= '0;
            exc_ip_q      <= '0;
            redir_pulse_q <= 1'b0;
            redir_tgt_q   <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            e_v_q         <= e_v_d;
            e_done_q      <= e_done_d;
            cmt_v_q       <= cmt_v_d;
            cmt_rfwr_q    <= cmt_rfwr_d;
            cmt_rt_q      <= cmt_rt_d;
            cmt_res_q     <= cmt_res_d;
            exc_q         <= exc_d;
            exc_cause_q   <= exc_cause_d;
            exc_ip_q      <= exc_ip_d;
            redir_pulse_q <= redir_pulse_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    // Entry payload is only meaningful while v is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        e_rfwr_q  <= e_rfwr_d;
        e_redir_q <= e_redir_d;
        e_ip_q    <= e_ip_d;
        e_tgt_q   <= e_tgt_d;
        e_rt_q    <= e_rt_d;
        e_cause_q <= e_cause_d;
        e_res_q   <= e_res_d;
    end

    assign alloc_rid_o = tail_idx;
    assign count_o     = count_w;
    assign empty_o     = (count_w == '0);
    assign cmt_v_o     = cmt_v_q;
    assign cmt_rfwr_o  = cmt_rfwr_q;
    assign cmt_Rt_o    = cmt_rt_q;
    assign cmt_res_o   = cmt_res_q;
    assign exc_o       = exc_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_ip_o    = exc_ip_q;
    assign redir_o     = redir_pulse_q;
    assign redir_tgt_o = redir_tgt_q;

endmodule

// File: tb/tb_any1_rob.sv
// Directed testbench for any1_rob (DEPTH=32, WB_PORTS=2, CMT_WIDTH=2).
module tb_any1_rob;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         alloc_i;
    logic [31:0]  alloc_ip_i;
    logic         alloc_rfwr_i;
    logic [7:0]   alloc_Rt_i;
    logic         alloc_ready_o;
    logic [4:0]   alloc_rid_o;
    logic [1:0]   wb_v_i;
    logic [9:0]   wb_rid_i;
    logic [127:0] wb_res_i;
    logic [31:0]  wb_cause_i;
    logic [1:0]   wb_redir_i;
    logic [63:0]  wb_tgt_i;
    logic [1:0]   cmt_v_o;
    logic [1:0]   cmt_rfwr_o;
    logic [15:0]  cmt_Rt_o;
    logic [127:0] cmt_res_o;
    logic         exc_o;
    logic [15:0]  exc_cause_o;
    logic [31:0]  exc_ip_o;
    logic         redir_o;
    logic [31:0]  redir_tgt_o;
    logic [5:0]   count_o;
    logic         empty_o;

    int checks = 0;
    int errors = 0;

    any1_rob #(.DEPTH(32), .WB_PORTS(2), .CMT_WIDTH(2), .AWID(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .alloc_i(alloc_i), .alloc_ip_i(alloc_ip_i), .alloc_rfwr_i(alloc_rfwr_i),
        .alloc_Rt_i(alloc_Rt_i), .alloc_ready_o(alloc_ready_o), .alloc_rid_o(alloc_rid_o),
        .wb_v_i(wb_v_i), .wb_rid_i(wb_rid_i), .wb_res_i(wb_res_i),
        .wb_cause_i(wb_cause_i), .wb_redir_i(wb_redir_i), .wb_tgt_i(wb_tgt_i),
        .cmt_v_o(cmt_v_o), .cmt_rfwr_o(cmt_rfwr_o), .cmt_Rt_o(cmt_Rt_o),
        .cmt_res_o(cmt_res_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
        .exc_ip_o(exc_ip_o), .redir_o(redir_o), .redir_tgt_o(redir_tgt_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] ip, input logic [7:0] rt);
        alloc_i      = 1'b1;
        alloc_ip_i   = ip;
        alloc_rfwr_i = 1'b1;
        alloc_Rt_i   = rt;
        tick();
        alloc_i      = 1'b0;
    endtask

    task automatic wb_set(input int p, input logic [4:0] rid, input logic [63:0] res,
                          input logic [15:0] cause, input logic redir, input logic [31:0] tgt);
        wb_v_i[p]            = 1'b1;
        wb_rid_i[p*5 +: 5]   = rid;
        wb_res_i[p*64 +: 64] = res;
        wb_cause_i[p*16 +: 16] = cause;
        wb_redir_i[p]        = redir;
        wb_tgt_i[p*32 +: 32] = tgt;
    endtask

    task automatic wb_clr();
        wb_v_i     = '0;
        wb_redir_i = '0;
        wb_cause_i = '0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; alloc_i = 1'b0; alloc_ip_i = '0;
        alloc_rfwr_i = 1'b0; alloc_Rt_i = '0;
        wb_v_i = '0; wb_rid_i = '0; wb_res_i = '0; wb_cause_i = '0;
        wb_redir_i = '0; wb_tgt_i = '0;
        tick(); tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_ready", alloc_ready_o, 1);
        chk("rst_rid", alloc_rid_o, 0);
        chk("rst_cmt_v", cmt_v_o, 0);
        chk("rst_cmt_res", cmt_res_o, 0);
        chk("rst_exc", exc_o, 0);
        chk("rst_redir", redir_o, 0);
        rst_ni = 1'b1;
        tick();

        // Fill all 32 entries, then try one more.
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("fill_rid_%0d", i), alloc_rid_o, i);
            chk($sformatf("fill_ready_%0d", i), alloc_ready_o, 1);
            do_alloc(32'h100 + 32'(i), 8'(i));
        end
        chk("full_ready", alloc_ready_o, 0);
        chk("full_count", count_o, 32);
        alloc_i = 1'b1;
        tick();
        alloc_i = 1'b0;
        chk("full_33rd_count", count_o, 32);
        chk("full_33rd_rid", alloc_rid_o, 0);
        flush_i = 1'b1;
        #1;
        chk("flush_ready_low", alloc_ready_o, 0);
        tick();
        flush_i = 1'b0;
        chk("flush_count", count_o, 0);
        chk("flush_cmt_v", cmt_v_o, 0);

        // Out-of-order writeback, in-order commit.
        for (int i = 0; i < 4; i++) do_alloc(32'h1000 + 32'(4*i), 8'(i + 1));
        for (int i = 3; i >= 1; i--) begin
            wb_set(0, 5'(i), 64'hA0 + 64'(i), 16'h0, 1'b0, 32'h0);
            tick();
            chk($sformatf("ooo_nocmt_%0d", i), cmt_v_o, 0);
        end
        wb_set(0, 5'd0, 64'hA0, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        chk("ooo_wb0_latency", cmt_v_o, 0);
        tick();
        chk("ooo_cmt01_v", cmt_v_o, 2'b11);
        chk("ooo_cmt01_rfwr", cmt_rfwr_o, 2'b11);
        chk("ooo_cmt01_rt", cmt_Rt_o, 16'h0201);
        chk("ooo_cmt01_res", cmt_res_o, {64'hA1, 64'hA0});
        tick();
        chk("ooo_cmt23_v", cmt_v_o, 2'b11);
        chk("ooo_cmt23_rt", cmt_Rt_o, 16'h0403);
        chk("ooo_empty", empty_o, 1);
        tick();
        chk("ooo_idle", cmt_v_o, 0);

        // Exception: rids 4..6, rid 5 faults.
        for (int i = 0; i < 3; i++) do_alloc(32'h2000 + 32'(4*i), 8'h10 + 8'(i));
        wb_set(0, 5'd4, 64'h44, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd5, 64'h55, 16'h0037, 1'b0, 32'h0);
        tick();
        wb_clr();
        wb_set(0, 5'd6, 64'h66, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        chk("exc_pre_cmt_v", cmt_v_o, 2'b01);
        chk("exc_pre_exc", exc_o, 0);
        chk("exc_pre_res", cmt_res_o[63:0], 64'h44);
        tick();
        chk("exc_pulse", exc_o, 1);
        chk("exc_cause", exc_cause_o, 16'h0037);
        chk("exc_ip", exc_ip_o, 32'h2004);
        chk("exc_cmt_v", cmt_v_o, 2'b01);
        chk("exc_cmt_rfwr", cmt_rfwr_o[0], 0);
        chk("exc_count", count_o, 0);
        tick();
        chk("exc_single_pulse", exc_o, 0);
        chk("exc_rid6_dropped", cmt_v_o, 0);

        // Redirect: rids 7..10, rid 7 mispredicted.
        for (int i = 0; i < 4; i++) do_alloc(32'h3000 + 32'(4*i), 8'h20 + 8'(i));
        wb_set(0, 5'd7, 64'h77, 16'h0, 1'b1, 32'hFFFD0100);
        wb_set(1, 5'd8, 64'h88, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        wb_set(0, 5'd9, 64'h99, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd10, 64'hAA, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        chk("redir_pulse", redir_o, 1);
        chk("redir_tgt", redir_tgt_o, 32'hFFFD0100);
        chk("redir_cmt_v", cmt_v_o, 2'b01);
        chk("redir_res", cmt_res_o[63:0], 64'h77);
        chk("redir_count", count_o, 0);
        tick();
        chk("redir_single_pulse", redir_o, 0);
        chk("redir_discard", cmt_v_o, 0);

        // Two ports hit rid 5 in the same cycle: port 0 wins.
        do_flush();
        for (int i = 0; i < 6; i++) do_alloc(32'h4000 + 32'(4*i), 8'h30 + 8'(i));
        wb_set(0, 5'd0, 64'hC0, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd1, 64'hC1, 16'h0, 1'b0, 32'h0);
        tick();
        wb_set(0, 5'd2, 64'hC2, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd3, 64'hC3, 16'h0, 1'b0, 32'h0);
        tick();
        chk("dup_cmt01", cmt_v_o, 2'b11);
        wb_set(0, 5'd5, 64'hAAAA, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd5, 64'hBBBB, 16'h0, 1'b0, 32'h0);
        tick();
        chk("dup_cmt23", cmt_v_o, 2'b11);
        wb_clr();
        wb_set(0, 5'd4, 64'hC4, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        chk("dup_stall_rid4", cmt_v_o, 0);
        tick();
        chk("dup_cmt45", cmt_v_o, 2'b11);
        chk("dup_port0_wins", cmt_res_o, {64'hAAAA, 64'hC4});

        // Wrap-around.
        do_flush();
        for (int i = 0; i < 30; i++) do_alloc(32'h5000 + 32'(4*i), 8'(i));
        wb_set(0, 5'd0, 64'hD0, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd1, 64'hD1, 16'h0, 1'b0, 32'h0);
        tick();
        wb_set(0, 5'd2, 64'hD2, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd3, 64'hD3, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        tick();
        chk("wrap_count26", count_o, 26);
        for (int j = 0; j < 6; j++) begin
            logic [4:0] exp_rid;
            exp_rid = 5'(30 + j);
            chk($sformatf("wrap_rid_%0d", j), alloc_rid_o, exp_rid);
            do_alloc(32'h6000 + 32'(4*j), 8'h80 + 8'(j));
        end
        chk("wrap_full_count", count_o, 32);
        chk("wrap_full_ready", alloc_ready_o, 0);
        for (int r = 4; r <= 30; r++) begin
            wb_set(0, 5'(r), 64'h100 + 64'(r), 16'h0, 1'b0, 32'h0);
            tick();
        end
        wb_clr();
        tick();
        tick();
        chk("wrap_count5", count_o, 5);
        wb_set(0, 5'd31, 64'hE31, 16'h0, 1'b0, 32'h0);
        wb_set(1, 5'd0, 64'hE00, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        tick();
        chk("wrap_span_v", cmt_v_o, 2'b11);
        chk("wrap_span_rt", cmt_Rt_o, 16'h8281);
        chk("wrap_span_res", cmt_res_o, {64'hE00, 64'hE31});
        chk("wrap_count3", count_o, 3);
        wb_set(0, 5'd1, 64'hE01, 16'h0, 1'b0, 32'h0);
        tick();
        wb_clr();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("midflush_cmt_v", cmt_v_o, 0);
        chk("midflush_count", count_o, 0);
        tick();
        chk("midflush_idle", cmt_v_o, 0);
        chk("midflush_ready", alloc_ready_o, 1);

        // Asynchronous reset in mid-operation.
        do_alloc(32'h7000, 8'h1);
        do_alloc(32'h7004, 8'h2);
        chk("pre_rst_count", count_o, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_count", count_o, 0);
        chk("async_rst_empty", empty_o, 1);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
